decoder_3to8: RTL and testbench

- Registered 3-to-8 one-hot binary decoder.
- Converts a 3-bit select code into an 8-bit one-hot output, one clock of latency.
- Used as a select/enable generator, e.g. bank, chip-select or register-write strobes, in synchronous datapaths.
- Single clock domain; asynchronous active-low reset.

---
 rtl/decoder_3to8.sv | 91 +++++++++
 tb/tb_decoder_3to8.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/decoder_3to8.sv
// ---------------------------------------------------------------------------
// decoder_3to8
//   Registered 3-to-8 one-hot decoder. A 3-bit select code becomes an 8-bit
//   one-hot strobe one clock later. Typical use: bank/chip-select or
//   register-write enables in a synchronous datapath.
//
// Parameters
//   OUT_ACTIVE_LOW : 0 -> selected bit is 1, idle pattern 8'h00
//                    1 -> selected bit is 0, idle pattern 8'hFF
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   decode enable; 0 selects no output line
//   a[2:0]     in   binary select code
//   y[7:0]     out  registered decode of a, polarity per OUT_ACTIVE_LOW
//   y_valid    out  registered copy of en
//   onehot_err out  sticky self-check flag      (DECODER_3TO8_ONEHOT_CHK_EN)
//   err_clr    in   synchronous clear of flag   (DECODER_3TO8_ONEHOT_CHK_EN)
//
// Build option
//   `define DECODER_3TO8_ONEHOT_CHK_EN adds a checker that watches the output
//   register and latches onehot_err when y is not a legal pattern for the
//   current y_valid. Decode behaviour and timing are identical either way.
// ---------------------------------------------------------------------------
module decoder_3to8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y,
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
  output logic       onehot_err,
  input  logic       err_clr,
`endif
  output logic       y_valid
);

  localparam logic [7:0] Y_IDLE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] w_d;      // active-high decode of the current inputs
  logic [7:0] w_y_nxt;  // w_d in output polarity
  logic [7:0] r_y;
  logic       r_y_valid;

  // An X/Z select propagates through the shift as X rather than being
  // forced onto some legal code, so bad stimulus stays visible in sim.
  assign w_d     = en ? (8'b1 << a) : 8'h00;
  assign w_y_nxt = OUT_ACTIVE_LOW ? ~w_d : w_d;

  // No warm-up cycle: the first edge after reset release loads a/en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= Y_IDLE;
      r_y_valid <= 1'b0;
    end else begin
      r_y       <= w_y_nxt;
      r_y_valid <= en;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;

`ifdef DECODER_3TO8_ONEHOT_CHK_EN
  logic [7:0] w_y_norm;  // registered y, normalized to active-high
  logic       w_err;
  logic       r_onehot_err;

  assign w_y_norm = OUT_ACTIVE_LOW ? ~r_y : r_y;

  // Valid output must be exactly one-hot; idle output must be all-inactive.
  always_comb begin
    w_err = 1'b0;
    if (r_y_valid) w_err = ($countones(w_y_norm) != 1);
    else           w_err = (w_y_norm != 8'h00);
  end

  // Sticky flag; a fresh error in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_onehot_err <= 1'b0;
    else if (w_err)   r_onehot_err <= 1'b1;
    else if (err_clr) r_onehot_err <= 1'b0;
  end

  assign onehot_err = r_onehot_err;
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Directed bench for decoder_3to8: an active-high and an active-low instance
// share the same stimulus. The onehot checker section is compiled only when
// DECODER_3TO8_ONEHOT_CHK_EN is defined.
module tb_decoder_3to8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] a;
  logic [7:0] y_hi, y_lo;
  logic       yv_hi, yv_lo;
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
  logic       err_hi, err_lo;
  logic       err_clr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .a          (a),
    .y          (y_hi),
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    .onehot_err (err_hi),
    .err_clr    (err_clr),
`endif
    .y_valid    (yv_hi)
  );

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .a          (a),
    .y          (y_lo),
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    .onehot_err (err_lo),
    .err_clr    (err_clr),
`endif
    .y_valid    (yv_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one active edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_hi [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] sweep_lo [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    a     = 3'd5;
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    err_clr = 1'b0;
`endif

    // reset held across several edges with live inputs
    repeat (3) tick();
    chk("rst_y",      y_hi,  8'h00);
    chk("rst_yv",     {7'b0, yv_hi}, 8'h00);
    chk("rst_y_lo",   y_lo,  8'hFF);
    chk("rst_yv_lo",  {7'b0, yv_lo}, 8'h00);
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    chk("rst_err",    {7'b0, err_hi}, 8'h00);
`endif

    // release between edges; first edge loads current inputs
    rst_n = 1'b1;

    // sweep, one code per cycle
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      tick();
      chk($sformatf("sweep_y%0d", i),    y_hi, sweep_hi[i]);
      chk($sformatf("sweep_yv%0d", i),   {7'b0, yv_hi}, 8'h01);
      chk($sformatf("sweep_ylo%0d", i),  y_lo, sweep_lo[i]);
`ifdef DECODER_3TO8_ONEHOT_CHK_EN
      chk($sformatf("sweep_err%0d", i),  {7'b0, err_hi}, 8'h00);
`endif
    end

    // enable gating
    en = 1'b0; a = 3'd3;
    tick();
    chk("gate_off_y",    y_hi, 8'h00);
    chk("gate_off_yv",   {7'b0, yv_hi}, 8'h00);
    chk("gate_off_ylo",  y_lo, 8'hFF);
    en = 1'b1;
    tick();
    chk("gate_on_y",     y_hi, 8'h08);
    chk("gate_on_yv",    {7'b0, yv_hi}, 8'h01);

    // active-low specific vectors
    a = 3'd6;
    tick();
    chk("lo_a6",     y_lo, 8'hBF);
    chk("lo_a6_yv",  {7'b0, yv_lo}, 8'h01);
    en = 1'b0;
    tick();
    chk("lo_en0",    y_lo, 8'hFF);

    // mid-stream async reset: clears between edges, no warm-up after release
    en = 1'b1; a = 3'd2;
    tick();
    chk("mid_pre_y",   y_hi, 8'h04);
    chk("mid_pre_yv",  {7'b0, yv_hi}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_y",   y_hi, 8'h00);
    chk("mid_async_yv",  {7'b0, yv_hi}, 8'h00);
    chk("mid_async_ylo", y_lo, 8'hFF);
    #1 rst_n = 1'b1;
    a = 3'd7;
    tick();
    chk("mid_post_y",  y_hi, 8'h80);
    chk("mid_post_yv", {7'b0, yv_hi}, 8'h01);

    // back-to-back distinct codes
    a = 3'd1;
    tick();
    chk("b2b_a1", y_hi, 8'h02);
    a = 3'd4;
    tick();
    chk("b2b_a4", y_hi, 8'h10);

`ifdef DECODER_3TO8_ONEHOT_CHK_EN
    // corrupt the output register with a two-hot value while valid
    a = 3'd0;
    tick();
    chk("chk_pre_err", {7'b0, err_hi}, 8'h00);
    force dut.r_y = 8'h03;
    tick();
    chk("chk_set_err", {7'b0, err_hi}, 8'h01);
    release dut.r_y;
    tick();
    chk("chk_sticky",  {7'b0, err_hi}, 8'h01);
    chk("chk_y_back",  y_hi, 8'h01);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("chk_clr_err", {7'b0, err_hi}, 8'h00);
    chk("chk_lo_err",  {7'b0, err_lo}, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard stop in case a bug stalls the stimulus thread
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
